// File: rtl/bus_slot_scheduler_pkg.sv
// Shared encodings for the bus slot scheduler: grant codes, DMA FSM states,
// phase boundary constants and the DMA source address helper.
package bus_slot_scheduler_pkg;

  localparam logic [1:0] GNT_IDLE   = 2'b00;
  localparam logic [1:0] GNT_MASTER = 2'b01;
  localparam logic [1:0] GNT_SLAVE  = 2'b10;
  localparam logic [1:0] GNT_DMA    = 2'b11;

  // Phase value at which each half-slot begins.
  localparam logic [1:0] PH_MSTART = 2'd0;
  localparam logic [1:0] PH_SSTART = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  // Work RAM source address; wraps within the 13-bit space.
  function automatic logic [12:0] dma_addr(input logic [12:0] base, input logic [12:0] offs);
    return base + offs;
  endfunction

endpackage

// File: rtl/bus_phase_gen.sv
// Free-running 4-phase counter of the shared bus: exposes 1H, 2H, S2H and the
// upcoming phase value so that other blocks can act on slot boundaries.
module bus_phase_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] h_next_o,
  output logic       clk_1h_o,
  output logic       clk_2h_o,
  output logic       clk_s2h_o
);

  logic [1:0] h_q;
  logic [1:0] h_d;

  assign h_d = h_q + 2'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= 2'd0;
    end else begin
      h_q <= h_d;
    end
  end

  assign h_next_o  = h_d;
  assign clk_1h_o  = h_q[0];
  assign clk_2h_o  = h_q[1];
  assign clk_s2h_o = h_q[1] ^ h_q[0];

endmodule

// File: rtl/bus_slot_scheduler.sv
// Shared-bus half-slot allocator for master CPU, slave CPU and the vblank object DMA.
// Build option BUS_DMA_FAIR_EN: DMA yields alternate slave halves to a requesting slave CPU.
module bus_slot_scheduler
  import bus_slot_scheduler_pkg::*;
#(
  parameter logic [12:0] DMA_BASE = 13'h1800,
  parameter int          DMA_LEN  = 256,
  parameter int          CNT_W    = 9
) (
  input  logic             CLK_6M,
  input  logic             rst,
  output logic             CLK_1H,
  output logic             CLK_2H,
  output logic             CLK_S2H,
  input  logic             nMREQ,
  input  logic             nSREQ,
  output logic             MRDY,
  output logic             SRDY,
  input  logic             DMA_START,
  output logic [12:0]      DMA_A,
  output logic [CNT_W-1:0] OBJ_A,
  output logic             OBJ_WE,
  output logic [1:0]       GRANT,
  output logic             DMA_BUSY,
  output logic             DMA_DONE
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DMA_LEN - 1);

  logic [1:0]       h_next;
  dma_state_e       state_q;
  logic [1:0]       grant_q;
  logic             mrdy_q;
  logic             srdy_q;
  logic             obj_we_q;
  logic             done_q;
  logic [CNT_W-1:0] idx_q;
  logic [1:0]       slave_grant_d;
  logic             dma_slot_d;
  logic             at_mstart;
  logic             at_sstart;
  logic             at_mrdy;
  logic             at_srdy;
`ifdef BUS_DMA_FAIR_EN
  logic             dma_turn_q;
`endif

  bus_phase_gen u_phase (
    .clk_i     (CLK_6M),
    .rst_i     (rst),
    .h_next_o  (h_next),
    .clk_1h_o  (CLK_1H),
    .clk_2h_o  (CLK_2H),
    .clk_s2h_o (CLK_S2H)
  );

  // Each condition is true on the edge that enters the named phase.
  assign at_mstart = (h_next == PH_MSTART);
  assign at_sstart = (h_next == PH_SSTART);
  assign at_mrdy   = (h_next == PH_MSTART + 2'd1);
  assign at_srdy   = (h_next == PH_SSTART + 2'd1);

  // ARM is included so the half that starts the burst is already a DMA half.
  always_comb begin
    dma_slot_d = (state_q == ST_ARM) || (state_q == ST_XFER);
`ifdef BUS_DMA_FAIR_EN
    dma_slot_d = dma_slot_d && (nSREQ || (state_q == ST_ARM) || dma_turn_q);
`endif
    if (dma_slot_d) begin
      slave_grant_d = GNT_DMA;
    end else if (!nSREQ) begin
      slave_grant_d = GNT_SLAVE;
    end else begin
      slave_grant_d = GNT_IDLE;
    end
  end

  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GNT_IDLE;
      mrdy_q     <= 1'b0;
      srdy_q     <= 1'b0;
      obj_we_q   <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
`ifdef BUS_DMA_FAIR_EN
      dma_turn_q <= 1'b1;
`endif
    end else begin
      mrdy_q   <= 1'b0;
      srdy_q   <= 1'b0;
      obj_we_q <= 1'b0;
      done_q   <= 1'b0;

      if (at_mstart) begin
        grant_q <= nMREQ ? GNT_IDLE : GNT_MASTER;
      end
      if (at_sstart) begin
        grant_q <= slave_grant_d;
`ifdef BUS_DMA_FAIR_EN
        dma_turn_q <= (slave_grant_d != GNT_DMA);
`endif
      end
      if (at_mrdy) begin
        mrdy_q <= (grant_q == GNT_MASTER);
      end
      if (at_srdy) begin
        srdy_q   <= (grant_q == GNT_SLAVE);
        obj_we_q <= (grant_q == GNT_DMA);
      end

      case (state_q)
        ST_IDLE: begin
          if (DMA_START) begin
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (at_sstart) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // The index advances on the edge that closes the write strobe.
          if (obj_we_q) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign GRANT    = grant_q;
  assign MRDY     = mrdy_q;
  assign SRDY     = srdy_q;
  assign OBJ_WE   = obj_we_q;
  assign OBJ_A    = idx_q;
  assign DMA_A    = dma_addr(DMA_BASE, 13'(idx_q));
  assign DMA_BUSY = (state_q != ST_IDLE);
  assign DMA_DONE = done_q;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Randomised bench for bus_slot_scheduler against a cycle-count/slot-level reference model.
module tb_bus_slot_scheduler;

  localparam logic [12:0] BASE = 13'h1FFE;
  localparam int          LEN  = 4;
  localparam int          CW   = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nMREQ = 1'b1;
  logic          nSREQ = 1'b1;
  logic          DMA_START = 1'b0;
  logic          CLK_1H, CLK_2H, CLK_S2H, MRDY, SRDY, OBJ_WE, DMA_BUSY, DMA_DONE;
  logic [12:0]   DMA_A;
  logic [CW-1:0] OBJ_A;
  logic [1:0]    GRANT;

  always #5 clk = ~clk;

  bus_slot_scheduler #(.DMA_BASE(BASE), .DMA_LEN(LEN), .CNT_W(CW)) dut (
    .CLK_6M(clk), .rst(rst), .CLK_1H(CLK_1H), .CLK_2H(CLK_2H), .CLK_S2H(CLK_S2H),
    .nMREQ(nMREQ), .nSREQ(nSREQ), .MRDY(MRDY), .SRDY(SRDY), .DMA_START(DMA_START),
    .DMA_A(DMA_A), .OBJ_A(OBJ_A), .OBJ_WE(OBJ_WE), .GRANT(GRANT),
    .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle count since reset, owner of the current half
  // (0 idle, 1 master, 2 slave, 3 DMA) and burst bookkeeping.
  int m_t, m_owner, m_count, strobes;
  bit m_armed, m_running, m_done, m_dma_turn;

  task automatic model_reset();
    m_t = 0; m_owner = 0; m_count = 0;
    m_armed = 0; m_running = 0; m_done = 0; m_dma_turn = 1;
  endtask

  task automatic check_outputs();
    int h;
    bit busy;
    h = m_t % 4;
    busy = m_armed | m_running | m_done;
    check_val("clk_1h", int'(CLK_1H), h % 2);
    check_val("clk_2h", int'(CLK_2H), h / 2);
    check_val("clk_s2h", int'(CLK_S2H), (h % 2) ^ (h / 2));
    check_val("grant", int'(GRANT), m_owner);
    check_val("mrdy", int'(MRDY), int'(h == 1 && m_owner == 1));
    check_val("srdy", int'(SRDY), int'(h == 3 && m_owner == 2));
    check_val("obj_we", int'(OBJ_WE), int'(h == 3 && m_owner == 3));
    check_val("dma_busy", int'(DMA_BUSY), int'(busy));
    check_val("dma_done", int'(DMA_DONE), int'(m_done));
    if (m_owner == 3 || !busy) begin
      check_val("obj_a", int'(OBJ_A), m_count);
      check_val("dma_a", int'(DMA_A), (int'(BASE) + m_count) % 8192);
    end
    if (h == 3 && m_owner == 3)
      $display("xfer idx=%0d dma_a=%04h obj_a=%0d obj_we=%0d", m_count, DMA_A, OBJ_A, OBJ_WE);
  endtask

  task automatic model_step(input bit mreq_n, input bit sreq_n, input bit start);
    int h, nh;
    bit busy_old, armed_old, dma;
    h = m_t % 4;
    nh = (h + 1) % 4;
    busy_old = m_armed | m_running | m_done;
    armed_old = m_armed;
    m_done = 0;
    if (h == 3 && m_owner == 3) begin
      m_count++;
      strobes++;
      if (m_count == LEN) begin
        m_running = 0; m_done = 1; m_count = 0;
        $display("burst done at cycle %0d", m_t + 1);
      end
    end
    if (!busy_old && start) m_armed = 1;
    if (nh == 0) m_owner = mreq_n ? 0 : 1;
    if (nh == 2) begin
      if (armed_old) begin
        m_armed = 0; m_running = 1; m_dma_turn = 1;
      end
      if (m_running) begin
`ifdef BUS_DMA_FAIR_EN
        dma = sreq_n || m_dma_turn;
`else
        dma = 1'b1;
`endif
        m_dma_turn = !dma;
        m_owner = dma ? 3 : 2;
      end else begin
        m_owner = sreq_n ? 0 : 2;
      end
    end
    m_t++;
  endtask

  task automatic run_cycle(input bit mreq_n, input bit sreq_n, input bit start);
    check_outputs();
    nMREQ = mreq_n;
    nSREQ = sreq_n;
    DMA_START = start;
    model_step(mreq_n, sreq_n, start);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (m_armed | m_running | m_done); n++) run_cycle(1'b1, 1'b1, 1'b0);
    check_val("idle_wait", int'(DMA_BUSY), 0);
  endtask

  initial begin
    int s0;
    strobes = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (16) run_cycle(1'b1, 1'b1, 1'b0);
    repeat (16) run_cycle(1'b0, 1'b0, 1'b0);

    // Burst started at h=1 with the slave CPU requesting throughout.
    while (m_t % 4 != 1) run_cycle(1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    repeat (50) run_cycle(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    wait_idle();

    // Starts at every phase, with a retrigger attempt while busy.
    for (int p = 0; p < 4; p++) begin
      while (m_t % 4 != p) run_cycle(1'b1, 1'b1, 1'b0);
      run_cycle(1'b1, 1'b0, 1'b1);
      repeat (7) run_cycle(1'b0, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b1);
      repeat (40) run_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 1500; i++)
      run_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

    // Reset in the middle of a burst, right after the second write strobe.
    wait_idle();
    s0 = strobes;
    run_cycle(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 80 && strobes < s0 + 2; n++) run_cycle(1'b1, 1'b0, 1'b0);
    check_val("strobes_before_reset", strobes - s0, 2);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b1);
    repeat (40) run_cycle(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
